trng_fifo_dwc: RTL and testbench

Parametrised data-width-converting FIFO for the TRNG datapath. Buffers wide entropy words from the ring-oscillator sampler/post-processor and delivers them as narrower words to the AXI/CPU readout side. Supports a configurable width ratio, depth, almost-full threshold and a standard or first-word-fall-through (FWFT) read mode. Sticky overflow and underflow flags report dropped or invalid transfers.

---
 rtl/trng_fifo_pkg.sv | 25 ++
 rtl/trng_fifo_ram.sv | 42 ++++
 rtl/trng_fifo_dwc.sv | 106 ++++++++++
 tb/tb_trng_fifo_dwc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/trng_fifo_pkg.sv
// Shared constants and elaboration helpers for the TRNG width-converting FIFO.
// TRNG_WORD_W / TRNG_BUS_W are also used by the sampler and the AXI readout.
package trng_fifo_pkg;

    localparam int TRNG_WORD_W = 64;
    localparam int TRNG_BUS_W  = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int ratio_of(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Slice index width; kept at least one bit so RATIO=1 still has a legal vector.
    function automatic int slice_w(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/trng_fifo_ram.sv
// Simple dual-port storage: one write port, one read port.
// SYNC_RD=1 gives a registered read (block RAM); SYNC_RD=0 a distributed async read.
module trng_fifo_ram
    import trng_fifo_pkg::*;
#(
    parameter int W       = TRNG_WORD_W,
    parameter int DEPTH   = 16,
    parameter bit SYNC_RD = 1'b1,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    if (SYNC_RD) begin : g_sync
        (* ram_style = "block" *) logic [W-1:0] mem [DEPTH];

        always_ff @(posedge clk)
            if (we) mem[waddr] <= wdata;

        // Output register resets so the read port powers up at zero.
        always_ff @(posedge clk or posedge rst)
            if (rst)     rdata <= '0;
            else if (re) rdata <= mem[raddr];
    end else begin : g_async
        (* ram_style = "distributed" *) logic [W-1:0] mem [DEPTH];
        logic unused_rd;

        always_ff @(posedge clk)
            if (we) mem[waddr] <= wdata;

        assign rdata     = mem[raddr];
        assign unused_rd = re ^ rst;
    end

endmodule

// File: rtl/trng_fifo_dwc.sv
// Width-converting FIFO: wide entropy words in, LSB-first narrow slices out.
// All status outputs are registered from the next-state word count and slice index.
module trng_fifo_dwc
    import trng_fifo_pkg::*;
#(
    parameter int IN_W      = TRNG_WORD_W,
    parameter int OUT_W     = TRNG_BUS_W,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter bit FWFT      = 1'b0,
    localparam int LW       = clog2(DEPTH * ratio_of(IN_W, OUT_W)) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  din,
    input  logic             rd_en,
    input  logic             clr_flags,
    output logic [OUT_W-1:0] dout,
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    localparam int RATIO = ratio_of(IN_W, OUT_W);
    localparam int RB    = clog2(RATIO);
    localparam int SLW   = slice_w(RATIO);
    localparam int PW    = clog2(DEPTH);
    localparam int WCW   = PW + 1;

    logic [PW-1:0]  w_ptr, r_ptr;
    logic [SLW-1:0] sl, sl_n;
    logic [WCW-1:0] wcnt, wcnt_n;
    logic [LW-1:0]  level_n;
    logic           wa, ra, free;
    logic [RATIO-1:0][OUT_W-1:0] rword;

    // Accept decisions use pre-edge flags only: no pass-through at full or empty.
    assign wa   = wr_en && !full;
    assign ra   = rd_en && !empty;
    assign free = ra && (sl == SLW'(RATIO - 1));

    always_comb begin
        sl_n = sl;
        if (ra) sl_n = free ? '0 : sl + 1'b1;
        wcnt_n = wcnt;
        if (wa && !free)      wcnt_n = wcnt + 1'b1;
        else if (free && !wa) wcnt_n = wcnt - 1'b1;
        level_n = (LW'(wcnt_n) << RB) - LW'(sl_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            sl          <= '0;
            wcnt        <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wa)   w_ptr <= w_ptr + 1'b1;
            if (free) r_ptr <= r_ptr + 1'b1;
            sl          <= sl_n;
            wcnt        <= wcnt_n;
            level       <= level_n;
            empty       <= (level_n == '0);
            full        <= (wcnt_n == WCW'(DEPTH));
            almost_full <= (wcnt_n >= WCW'(AF_THRESH));
            // A fresh error on the clear cycle keeps the flag set.
            overflow    <= (wr_en && full)  || (overflow  && !clr_flags);
            underflow   <= (rd_en && empty) || (underflow && !clr_flags);
        end
    end

    trng_fifo_ram #(.W(IN_W), .DEPTH(DEPTH), .SYNC_RD(!FWFT)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wa),
        .waddr (w_ptr),
        .wdata (din),
        .re    (ra),
        .raddr (r_ptr),
        .rdata (rword)
    );

    if (FWFT) begin : g_fwft
        assign dout = empty ? '0 : rword[sl];
    end else begin : g_std
        // The RAM latches the whole word; remember which slice was popped with it.
        logic [SLW-1:0] sl_q;

        always_ff @(posedge clk or posedge rst)
            if (rst)     sl_q <= '0;
            else if (ra) sl_q <= sl;

        assign dout = rword[sl_q];
    end

endmodule

// File: tb/tb_trng_fifo_dwc.sv
// Directed bench: 64->32 standard-read FIFO plus an 8-bit FWFT plain FIFO.
module tb_trng_fifo_dwc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: IN_W=64, OUT_W=32, DEPTH=16, FWFT=0
    logic        rst_a, wr_a, rd_a, clr_a;
    logic [63:0] din_a;
    logic [31:0] dout_a;
    logic        full_a, af_a, empty_a, ov_a, un_a;
    logic [5:0]  level_a;

    // Instance B: IN_W=OUT_W=8, DEPTH=4, FWFT=1
    logic        rst_b, wr_b, rd_b, clr_b;
    logic [7:0]  din_b, dout_b;
    logic        full_b, af_b, empty_b, ov_b, un_b;
    logic [2:0]  level_b;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exq[$];
    logic [31:0] exp_w;
    logic        pre;

    trng_fifo_dwc #(.IN_W(64), .OUT_W(32), .DEPTH(16), .FWFT(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .wr_en(wr_a), .din(din_a), .rd_en(rd_a),
        .clr_flags(clr_a), .dout(dout_a), .full(full_a), .almost_full(af_a),
        .empty(empty_a), .level(level_a), .overflow(ov_a), .underflow(un_a)
    );

    trng_fifo_dwc #(.IN_W(8), .OUT_W(8), .DEPTH(4), .FWFT(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .wr_en(wr_b), .din(din_b), .rd_en(rd_b),
        .clr_flags(clr_b), .dout(dout_b), .full(full_b), .almost_full(af_b),
        .empty(empty_b), .level(level_b), .overflow(ov_b), .underflow(un_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0; din_a = '0;
        rst_b = 1'b1; wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0; din_b = '0;
        step(); step();
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_af", af_a, 0);
        chk("rst_level", level_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_ov", ov_a, 0);
        chk("rst_un", un_a, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // Basic write then two LSB-first reads
        wr_a = 1'b1; din_a = 64'h1111_2222_3333_4444;
        step();
        wr_a = 1'b0;
        chk("wr1_level", level_a, 2);
        chk("wr1_empty", empty_a, 0);
        rd_a = 1'b1;
        step();
        chk("rd1_dout", dout_a, 32'h3333_4444);
        chk("rd1_level", level_a, 1);
        step();
        rd_a = 1'b0;
        chk("rd2_dout", dout_a, 32'h1111_2222);
        chk("rd2_level", level_a, 0);
        chk("rd2_empty", empty_a, 1);

        // Read while empty
        rd_a = 1'b1;
        step();
        rd_a = 1'b0;
        chk("uf_flag", un_a, 1);
        chk("uf_dout", dout_a, 32'h1111_2222);
        chk("uf_level", level_a, 0);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("uf_clr", un_a, 0);

        // Fill to DEPTH; almost_full from the 14th word
        for (int i = 0; i < 16; i++) begin
            wr_a = 1'b1; din_a = {32'(32'h1000 + i), 32'(32'h2000 + i)};
            step();
            chk("fill_af", af_a, (i + 1 >= 14) ? 1 : 0);
        end
        chk("fill_full", full_a, 1);
        chk("fill_level", level_a, 32);
        din_a = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        wr_a = 1'b0;
        chk("of_flag", ov_a, 1);
        chk("of_level", level_a, 32);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("of_clr", ov_a, 0);

        // Write and read together at full: write dropped, one slice out
        wr_a = 1'b1; rd_a = 1'b1; din_a = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        wr_a = 1'b0;
        chk("wrfull_ov", ov_a, 1);
        chk("wrfull_level", level_a, 31);
        chk("wrfull_dout", dout_a, 32'h2000);
        clr_a = 1'b1;
        for (int k = 1; k < 32; k++) begin
            step();
            clr_a = 1'b0;
            exp_w = (k % 2 == 1) ? 32'(32'h1000 + k / 2) : 32'(32'h2000 + k / 2);
            chk("drain_dout", dout_a, exp_w);
        end
        rd_a = 1'b0;
        chk("drain_empty", empty_a, 1);
        chk("drain_level", level_a, 0);
        chk("drain_ov", ov_a, 0);

        // Stream 40 words at half rate with rd_en held high; pointers wrap
        rd_a = 1'b1;
        for (int k = 0; k < 40; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                wr_a = (ph == 0);
                din_a = {32'(32'hC000_0000 + 2 * k + 1), 32'(32'hC000_0000 + 2 * k)};
                if (ph == 0) begin
                    exq.push_back(din_a[31:0]);
                    exq.push_back(din_a[63:32]);
                end
                pre = !empty_a;
                step();
                if (pre) begin
                    if (exq.size() == 0) chk("stream_extra", 1, 0);
                    else chk("stream_dout", dout_a, exq.pop_front());
                end
                chk("stream_lvl_bound", (level_a <= 32), 1);
            end
        end
        wr_a = 1'b0;
        for (int c = 0; c < 20 && exq.size() > 0; c++) begin
            pre = !empty_a;
            step();
            if (pre) chk("stream_dout", dout_a, exq.pop_front());
        end
        rd_a = 1'b0;
        chk("stream_left", exq.size(), 0);
        chk("stream_ov", ov_a, 0);
        chk("stream_empty", empty_a, 1);

        // FWFT, RATIO=1
        chk("fw_rst_empty", empty_b, 1);
        chk("fw_rst_dout", dout_b, 0);
        wr_b = 1'b1; din_b = 8'hA5;
        step();
        chk("fw_empty", empty_b, 0);
        chk("fw_dout", dout_b, 8'hA5);
        din_b = 8'h3C;
        step();
        wr_b = 1'b0;
        chk("fw_hold", dout_b, 8'hA5);
        chk("fw_level2", level_b, 2);
        rd_b = 1'b1;
        step();
        rd_b = 1'b0;
        chk("fw_next", dout_b, 8'h3C);
        chk("fw_level1", level_b, 1);
        wr_b = 1'b1; din_b = 8'h77;
        step();
        wr_b = 1'b0;
        rst_b = 1'b1;
        #1;
        chk("fw_arst_empty", empty_b, 1);
        chk("fw_arst_dout", dout_b, 0);
        chk("fw_arst_level", level_b, 0);
        step();
        rst_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
